// File: rtl/yarp_dmem_responder.sv
// Data-memory responder for the yarp core: one access at a time, WAIT_CYCLES wait states, single-cycle response.
// Define YARP_DMEM_MISALIGN_ERR_EN to flag misaligned half/word accesses as errors instead of aligning them.
module yarp_dmem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        data_req_i,
    input  logic [31:0] data_addr_i,
    input  logic [1:0]  data_byte_i,
    input  logic        data_wr_i,
    input  logic [31:0] data_wr_data_i,
    output logic        data_ready_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rd_data_o,
    output logic        data_err_o
);
    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        ready_q;
    logic        rvalid_q;
    logic [31:0] rd_data_q;
    logic        err_q;
    logic [31:0] hold_data_q;
    logic        hold_err_q;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic [31:0] off;
    logic [1:0]  lo;
    logic [AW-1:0] idx;
    logic        range_err;
    logic        size_err;
    logic        align_err;
    logic        acc_err;
    logic        accept;
    logic        wr_en;
    logic [31:0] word_rd;
    logic [31:0] load_data;
    logic [31:0] resp_data;
    logic [3:0]  lane_en;
    logic [31:0] wr_word;

    always_comb begin
        off       = data_addr_i - BASE_ADDR;
        range_err = (off[31:2] >= 30'(DEPTH_WORDS));
        size_err  = (data_byte_i == 2'b10);
`ifdef YARP_DMEM_MISALIGN_ERR_EN
        align_err = ((data_byte_i == 2'b01) && off[0]) ||
                    ((data_byte_i == 2'b11) && (off[1:0] != 2'b00));
        lo        = off[1:0];
`else
        align_err = 1'b0;
        // Misaligned halves/words fall back to the aligned address.
        case (data_byte_i)
            2'b01:   lo = {off[1], 1'b0};
            2'b11:   lo = 2'b00;
            default: lo = off[1:0];
        endcase
`endif
        acc_err = range_err | size_err | align_err;
        idx     = off[AW+1:2];
        accept  = reset_n & data_req_i & ready_q;
        wr_en   = accept & data_wr_i & ~acc_err;
        word_rd = mem_q[idx];

        load_data = 32'd0;
        lane_en   = 4'b0000;
        wr_word   = data_wr_data_i;
        case (data_byte_i)
            2'b00: begin
                load_data = {24'd0, word_rd[{lo, 3'b000} +: 8]};
                lane_en   = 4'b0001 << lo;
                wr_word   = {4{data_wr_data_i[7:0]}};
            end
            2'b01: begin
                load_data = {16'd0, word_rd[{lo[1], 4'b0000} +: 16]};
                lane_en   = 4'b0011 << {lo[1], 1'b0};
                wr_word   = {2{data_wr_data_i[15:0]}};
            end
            2'b11: begin
                load_data = word_rd;
                lane_en   = 4'b1111;
            end
            default: begin
                load_data = 32'd0;
                lane_en   = 4'b0000;
            end
        endcase
        resp_data = (data_wr_i | acc_err) ? 32'd0 : load_data;
    end

    // The array is deliberately left out of reset; a committed store survives a reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_en[b]) mem_q[idx][8*b +: 8] <= wr_word[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            ready_q     <= 1'b1;
            rvalid_q    <= 1'b0;
            rd_data_q   <= 32'd0;
            err_q       <= 1'b0;
            hold_data_q <= 32'd0;
            hold_err_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        ready_q     <= 1'b0;
                        hold_data_q <= resp_data;
                        hold_err_q  <= acc_err;
                        if (WAIT_CYCLES == 0) begin
                            state_q   <= ST_RESP;
                            rvalid_q  <= 1'b1;
                            rd_data_q <= resp_data;
                            err_q     <= acc_err;
                        end else begin
                            state_q <= ST_WAIT;
                            cnt_q   <= CNT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q   <= ST_RESP;
                        rvalid_q  <= 1'b1;
                        rd_data_q <= hold_data_q;
                        err_q     <= hold_err_q;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_RESP: begin
                    state_q   <= ST_IDLE;
                    ready_q   <= 1'b1;
                    rvalid_q  <= 1'b0;
                    rd_data_q <= 32'd0;
                    err_q     <= 1'b0;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    cnt_q     <= 4'd0;
                    ready_q   <= 1'b1;
                    rvalid_q  <= 1'b0;
                    rd_data_q <= 32'd0;
                    err_q     <= 1'b0;
                end
            endcase
        end
    end

    assign data_ready_o   = ready_q;
    assign data_rvalid_o  = rvalid_q;
    assign data_rd_data_o = rd_data_q;
    assign data_err_o     = err_q;

endmodule

// File: tb/tb_yarp_dmem_responder.sv
// Directed bench for yarp_dmem_responder: three instances with WAIT_CYCLES 1, 0 and 3.
// Misalignment expectations follow YARP_DMEM_MISALIGN_ERR_EN as defined for the build.
module tb_yarp_dmem_responder;
    localparam int          WC [3] = '{1, 0, 3};
    localparam logic [31:0] BA [3] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_1000};

    logic        clk = 1'b0;
    logic        rst_n   [3];
    logic        req     [3];
    logic [31:0] addr    [3];
    logic [1:0]  sz      [3];
    logic        wr      [3];
    logic [31:0] wdata   [3];
    logic        rdy     [3];
    logic        rv      [3];
    logic [31:0] rd      [3];
    logic        er      [3];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        yarp_dmem_responder #(
            .BASE_ADDR   (BA[g]),
            .DEPTH_WORDS (1024),
            .WAIT_CYCLES (WC[g])
        ) u_dut (
            .clk            (clk),
            .reset_n        (rst_n[g]),
            .data_req_i     (req[g]),
            .data_addr_i    (addr[g]),
            .data_byte_i    (sz[g]),
            .data_wr_i      (wr[g]),
            .data_wr_data_i (wdata[g]),
            .data_ready_o   (rdy[g]),
            .data_rvalid_o  (rv[g]),
            .data_rd_data_o (rd[g]),
            .data_err_o     (er[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full access: request, response latency/data/error, then return to idle.
    task automatic access(input int d, input string tag, input logic w, input logic [1:0] s,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err);
        int lat;
        @(negedge clk);
        chk({tag, "_rdy_pre"}, 32'(rdy[d]), 32'd1);
        req[d] = 1'b1; wr[d] = w; sz[d] = s; addr[d] = a; wdata[d] = wd;
        @(posedge clk);
        @(negedge clk);
        req[d] = 1'b0; wr[d] = ~w; sz[d] = ~s; addr[d] = ~a; wdata[d] = ~wd;
        lat = 0;
        while (!rv[d] && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(WC[d]));
        chk({tag, "_rd"}, rd[d], exp_rd);
        chk({tag, "_err"}, 32'(er[d]), 32'(exp_err));
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(rv[d]), 32'd0);
        chk({tag, "_rd_idle"}, rd[d], 32'd0);
        chk({tag, "_rdy_post"}, 32'(rdy[d]), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        int nrv;
        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b0; req[i] = 1'b0; addr[i] = 32'd0; sz[i] = 2'b11;
            wr[i] = 1'b0; wdata[i] = 32'd0;
        end

        // Reset held 3 cycles with a store request pending on instance 0.
        req[0] = 1'b1; wr[0] = 1'b1; sz[0] = 2'b11; addr[0] = 32'h0; wdata[0] = 32'h1111_2222;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_rdy", 32'(rdy[0]), 32'd1);
            chk("rst_rv", 32'(rv[0]), 32'd0);
        end
        chk("rst_rd", rd[0], 32'd0);
        chk("rst_err", 32'(er[0]), 32'd0);
        chk("rst_rdy_d1", 32'(rdy[1]), 32'd1);
        chk("rst_rdy_d2", 32'(rdy[2]), 32'd1);
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rel_accept", 32'(rdy[0]), 32'd0);
        req[0] = 1'b0;
        k = 0;
        while (!rv[0] && k < 20) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        chk("rel_rv", 32'(rv[0]), 32'd1);
        chk("rel_err", 32'(er[0]), 32'd0);
        @(posedge clk);
        access(0, "rel_ld", 1'b0, 2'b11, 32'h0, 32'h0, 32'h1111_2222, 1'b0);

        // Word round trip and lane accesses, WAIT_CYCLES=1.
        access(0, "st_w10",  1'b1, 2'b11, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
        access(0, "ld_w10",  1'b0, 2'b11, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
        access(0, "st_b13",  1'b1, 2'b00, 32'h13, 32'h1234_56A5, 32'h0, 1'b0);
        access(0, "ld_w10b", 1'b0, 2'b11, 32'h10, 32'h0, 32'hA5AD_BEEF, 1'b0);
        access(0, "ld_b13",  1'b0, 2'b00, 32'h13, 32'h0, 32'h0000_00A5, 1'b0);
        access(0, "ld_h12",  1'b0, 2'b01, 32'h12, 32'h0, 32'h0000_A5AD, 1'b0);
        access(0, "ld_b10",  1'b0, 2'b00, 32'h10, 32'h0, 32'h0000_00EF, 1'b0);
        access(0, "ld_h10",  1'b0, 2'b01, 32'h10, 32'h0, 32'h0000_BEEF, 1'b0);
        access(0, "st_w14",  1'b1, 2'b11, 32'h14, 32'h0000_0000, 32'h0, 1'b0);
        access(0, "st_h16",  1'b1, 2'b01, 32'h16, 32'hFFFF_7E57, 32'h0, 1'b0);
        access(0, "ld_w14",  1'b0, 2'b11, 32'h14, 32'h0, 32'h7E57_0000, 1'b0);

        // Misaligned and illegal-size accesses.
`ifdef YARP_DMEM_MISALIGN_ERR_EN
        access(0, "st_w11",  1'b1, 2'b11, 32'h11, 32'h0102_0304, 32'h0, 1'b1);
        access(0, "ld_w10m", 1'b0, 2'b11, 32'h10, 32'h0, 32'hA5AD_BEEF, 1'b0);
        access(0, "ld_h11",  1'b0, 2'b01, 32'h11, 32'h0, 32'h0, 1'b1);
`else
        access(0, "st_w11",  1'b1, 2'b11, 32'h11, 32'h0102_0304, 32'h0, 1'b0);
        access(0, "ld_w10m", 1'b0, 2'b11, 32'h10, 32'h0, 32'h0102_0304, 1'b0);
        access(0, "ld_h11",  1'b0, 2'b01, 32'h11, 32'h0, 32'h0000_0304, 1'b0);
`endif
        access(0, "st_sz10", 1'b1, 2'b10, 32'h14, 32'hFFFF_FFFF, 32'h0, 1'b1);
        access(0, "ld_sz10", 1'b0, 2'b10, 32'h14, 32'h0, 32'h0, 1'b1);
        access(0, "ld_w14s", 1'b0, 2'b11, 32'h14, 32'h0, 32'h7E57_0000, 1'b0);

        // Out of range, including the wrap below BASE_ADDR.
        access(0, "ld_oor",  1'b0, 2'b11, 32'h0000_1000, 32'h0, 32'h0, 1'b1);
        access(0, "st_oor",  1'b1, 2'b11, 32'h0000_1000, 32'h5555_5555, 32'h0, 1'b1);
        access(0, "ld_wrap", 1'b0, 2'b11, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b1);
        access(2, "ld_below", 1'b0, 2'b11, 32'h0000_0FFC, 32'h0, 32'h0, 1'b1);
        access(2, "ld_top",   1'b0, 2'b00, 32'h0000_2000, 32'h0, 32'h0, 1'b1);
        access(2, "st_w3",    1'b1, 2'b11, 32'h0000_1010, 32'h8765_4321, 32'h0, 1'b0);
        access(2, "ld_h3",    1'b0, 2'b01, 32'h0000_1012, 32'h0, 32'h0000_8765, 1'b0);

        // WAIT_CYCLES=0 with request held high: accepted every second edge.
        @(negedge clk);
        req[1] = 1'b1; wr[1] = 1'b1; sz[1] = 2'b11; addr[1] = 32'h20; wdata[1] = 32'h5A5A_0001;
        nrv = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_rv", 32'(rv[1]), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("hold_rdy", 32'(rdy[1]), (i % 2 == 1) ? 32'd1 : 32'd0);
            if (rv[1]) nrv++;
        end
        req[1] = 1'b0;
        chk("hold_count", 32'(nrv), 32'd3);
        access(1, "hold_ld", 1'b0, 2'b11, 32'h20, 32'h0, 32'h5A5A_0001, 1'b0);

        // WAIT_CYCLES=3: reset during WAIT drops the response but keeps the store.
        @(negedge clk);
        req[2] = 1'b1; wr[2] = 1'b1; sz[2] = 2'b11; addr[2] = 32'h0000_1040; wdata[2] = 32'hCAFE_F00D;
        @(posedge clk);
        @(negedge clk);
        req[2] = 1'b0;
        chk("mid_busy", 32'(rdy[2]), 32'd0);
        rst_n[2] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_rv", 32'(rv[2]), 32'd0);
        chk("mid_rst_rdy", 32'(rdy[2]), 32'd1);
        rst_n[2] = 1'b1;
        nrv = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (rv[2]) nrv++;
        end
        chk("mid_no_rv", 32'(nrv), 32'd0);
        access(2, "mid_ld", 1'b0, 2'b11, 32'h0000_1040, 32'h0, 32'hCAFE_F00D, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
